// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extends I/S/B/J/U/Z immediates to XLEN
// and delivers them through a 1- or 2-deep valid/ready register pipeline.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;
    localparam logic [2:0] SRC_Z = 3'b101;

    // Each replication count stays >= 1 for both legal XLEN values.
    function automatic logic [XLEN-1:0] extend_imm(input logic [31:0] ins,
                                                   input logic [2:0]  src);
        logic s;
        s = ins[31];
        case (src)
            SRC_I:   return {{(XLEN-11){s}}, ins[30:20]};
            SRC_S:   return {{(XLEN-11){s}}, ins[30:25], ins[11:7]};
            SRC_B:   return {{(XLEN-12){s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            SRC_J:   return {{(XLEN-20){s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            SRC_U:   return {{(XLEN-31){s}}, ins[30:12], 12'b0};
            SRC_Z:   return {{(XLEN-5){1'b0}}, ins[19:15]};
            default: return '0;
        endcase
    endfunction

    function automatic logic is_reserved(input logic [2:0] src);
        return src[2] & src[1];
    endfunction

    logic [XLEN-1:0] ext_imm;
    logic            ext_ill;
    logic            load_p0;
    logic            load_last;
    logic            unused_opcode;

    assign ext_imm       = extend_imm(instr, immsrc);
    assign ext_ill       = is_reserved(immsrc);
    assign unused_opcode = ^instr[6:0];
    assign in_ready      = load_p0;

    logic            vld_p0_q, vld_p0_d;
    logic            ill_p0_q, ill_p0_d;
    logic [XLEN-1:0] imm_p0_q, imm_p0_d;

    // Stage 0: capture the freshly extended immediate
    always_comb begin
        vld_p0_d = vld_p0_q;
        imm_p0_d = imm_p0_q;
        ill_p0_d = ill_p0_q;
        if (load_p0) begin
            vld_p0_d = in_valid;
            if (in_valid) begin
                imm_p0_d = ext_imm;
                ill_p0_d = ext_ill;
            end
        end
        if (flush) begin
            vld_p0_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0_q <= 1'b0;
            imm_p0_q <= '0;
            ill_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= vld_p0_d;
            imm_p0_q <= imm_p0_d;
            ill_p0_q <= ill_p0_d;
        end
    end

    generate
        if (STAGES == 2) begin : g_two_stage
            logic            vld_p1_q, vld_p1_d;
            logic            ill_p1_q, ill_p1_d;
            logic [XLEN-1:0] imm_p1_q, imm_p1_d;

            assign load_last = !vld_p1_q || out_ready;
            assign load_p0   = !vld_p0_q || load_last;

            // Stage 1: copy the stage-0 payload forward unchanged
            always_comb begin
                vld_p1_d = vld_p1_q;
                imm_p1_d = imm_p1_q;
                ill_p1_d = ill_p1_q;
                if (load_last) begin
                    vld_p1_d = vld_p0_q;
                    if (vld_p0_q) begin
                        imm_p1_d = imm_p0_q;
                        ill_p1_d = ill_p0_q;
                    end
                end
                if (flush) begin
                    vld_p1_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p1_q <= 1'b0;
                    imm_p1_q <= '0;
                    ill_p1_q <= 1'b0;
                end else begin
                    vld_p1_q <= vld_p1_d;
                    imm_p1_q <= imm_p1_d;
                    ill_p1_q <= ill_p1_d;
                end
            end

            assign out_valid = vld_p1_q;
            assign immext    = imm_p1_q;
            assign illegal   = ill_p1_q;
        end else begin : g_one_stage
            assign load_last = !vld_p0_q || out_ready;
            assign load_p0   = load_last;

            assign out_valid = vld_p0_q;
            assign immext    = imm_p0_q;
            assign illegal   = ill_p0_q;
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/1-stage and a 64-bit/2-stage instance share
// one stimulus stream and are checked against an arithmetic queue model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  immsrc;

    logic        ir_a, ov_a, ill_a;
    logic [31:0] imm_a;
    logic        ir_b, ov_b, ill_b;
    logic [63:0] imm_b;

    imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .instr(instr), .immsrc(immsrc), .out_valid(ov_a), .out_ready(out_ready),
        .immext(imm_a), .illegal(ill_a)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .instr(instr), .immsrc(immsrc), .out_valid(ov_b), .out_ready(out_ready),
        .immext(imm_b), .illegal(ill_b)
    );

    logic        ir_w [2];
    logic        ov_w [2];
    logic        ill_w [2];
    logic [63:0] imm_w [2];

    assign ir_w[0]  = ir_a;
    assign ir_w[1]  = ir_b;
    assign ov_w[0]  = ov_a;
    assign ov_w[1]  = ov_b;
    assign ill_w[0] = ill_a;
    assign ill_w[1] = ill_b;
    assign imm_w[0] = {32'b0, imm_a};
    assign imm_w[1] = imm_b;

    int vectors = 0;
    int errors  = 0;

    // Model: per instance, an ordered list of in-flight items with their age in cycles.
    int          cnt [2];
    logic [63:0] m_imm [2][2];
    logic        m_ill [2][2];
    int          m_age [2][2];

    function automatic int depth(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic exp_ready(int d);
        return (cnt[d] < depth(d)) || out_ready;
    endfunction

    function automatic logic exp_valid(int d);
        return (cnt[d] > 0) && (m_age[d][0] >= depth(d));
    endfunction

    function automatic logic [63:0] sext(longint raw, int w);
        if (raw >= (longint'(1) << (w - 1))) return raw - (longint'(1) << w);
        return raw;
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] src);
        case (src)
            3'd0:    return sext(longint'(ins[31:20]), 12);
            3'd1:    return sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            3'd2:    return sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                                 longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            3'd3:    return sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                                 longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            3'd4:    return sext(longint'(ins[31:12]) * 4096, 32);
            3'd5:    return longint'(ins[19:15]);
            default: return 64'd0;
        endcase
    endfunction

    // Advance one clock and update the model from the values presented before the edge.
    task automatic tick();
        logic        rdy [2];
        logic        vld [2];
        logic [63:0] v;
        for (int d = 0; d < 2; d++) begin
            rdy[d] = exp_ready(d);
            vld[d] = exp_valid(d);
        end
        v = ref_imm(instr, immsrc);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                cnt[d] = 0;
            end else begin
                if (vld[d] && out_ready) begin
                    m_imm[d][0] = m_imm[d][1];
                    m_ill[d][0] = m_ill[d][1];
                    m_age[d][0] = m_age[d][1];
                    cnt[d]--;
                end
                if (flush) begin
                    cnt[d] = 0;
                end else if (in_valid && rdy[d]) begin
                    m_imm[d][cnt[d]] = (d == 0) ? {32'b0, v[31:0]} : v;
                    m_ill[d][cnt[d]] = (immsrc >= 3'd6);
                    m_age[d][cnt[d]] = 0;
                    cnt[d]++;
                end
                for (int i = 0; i < cnt[d]; i++) m_age[d][i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; immsrc = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (ov_w[d] !== 1'b0 || imm_w[d] !== 64'd0 || ill_w[d] !== 1'b0 || ir_w[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset dut%0d: got vld=%b imm=%h ill=%b rdy=%b, want 0/0/0/1",
                         d, ov_w[d], imm_w[d], ill_w[d], ir_w[d]);
            end
        end
    endtask

    task automatic test_formats();
        logic [31:0] ins [4] = '{32'hFFF00093, 32'h800000B7, 32'h7FF00093, 32'hFFFFFFFF};
        logic [2:0]  src [4] = '{3'd0, 3'd4, 3'd0, 3'd6};
        logic [31:0] ea  [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h000007FF, 32'h0};
        logic [63:0] eb  [4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h7FF, 64'h0};
        logic        il  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            if (i < 4) begin instr = ins[i]; immsrc = src[i]; end
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (ir_w[d] !== exp_ready(d) || ov_w[d] !== exp_valid(d) ||
                    (exp_valid(d) && (imm_w[d] !== m_imm[d][0] || ill_w[d] !== m_ill[d][0]))) begin
                    errors++;
                    $display("FAIL formats_model dut%0d: got rdy=%b vld=%b imm=%h ill=%b, want rdy=%b vld=%b imm=%h ill=%b",
                             d, ir_w[d], ov_w[d], imm_w[d], ill_w[d], exp_ready(d), exp_valid(d), m_imm[d][0], m_ill[d][0]);
                end
            end
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (ov_a !== 1'b1 || imm_a !== ea[i-1] || ill_a !== il[i-1]) begin
                    errors++;
                    $display("FAIL formats_x32 item%0d: got vld=%b imm=%h ill=%b, want 1 %h %b",
                             i - 1, ov_a, imm_a, ill_a, ea[i-1], il[i-1]);
                end
            end
            if (i >= 2) begin
                vectors++;
                if (ov_b !== 1'b1 || imm_b !== eb[i-2] || ill_b !== il[i-2]) begin
                    errors++;
                    $display("FAIL formats_x64 item%0d: got vld=%b imm=%h ill=%b, want 1 %h %b",
                             i - 2, ov_b, imm_b, ill_b, eb[i-2], il[i-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4] = '{32'hFE000C23, 32'hFE000EE3, 32'h0010006F, 32'h000F8073};
        logic [2:0]  src [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [31:0] ea  [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000800, 32'h0000001F};
        logic [63:0] eb  [4] = '{64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, 64'h800, 64'h1F};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            if (i < 4) begin instr = ins[i]; immsrc = src[i]; end
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (ir_w[d] !== exp_ready(d) || ov_w[d] !== exp_valid(d) ||
                    (exp_valid(d) && (imm_w[d] !== m_imm[d][0] || ill_w[d] !== m_ill[d][0]))) begin
                    errors++;
                    $display("FAIL b2b_model dut%0d: got rdy=%b vld=%b imm=%h ill=%b, want rdy=%b vld=%b imm=%h ill=%b",
                             d, ir_w[d], ov_w[d], imm_w[d], ill_w[d], exp_ready(d), exp_valid(d), m_imm[d][0], m_ill[d][0]);
                end
            end
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (ov_a !== 1'b1 || imm_a !== ea[i-1] || ill_a !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_x32 item%0d: got vld=%b imm=%h ill=%b, want 1 %h 0",
                             i - 1, ov_a, imm_a, ill_a, ea[i-1]);
                end
            end
            if (i >= 2) begin
                vectors++;
                if (ov_b !== 1'b1 || imm_b !== eb[i-2] || ill_b !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_x64 item%0d: got vld=%b imm=%h ill=%b, want 1 %h 0",
                             i - 2, ov_b, imm_b, ill_b, eb[i-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] item [3] = '{32'h00100093, 32'h00200093, 32'h00300093};
        drain();
        immsrc = 3'd0;
        for (int c = 0; c < 8; c++) begin
            in_valid  = (c < 5);
            instr     = item[(c < 2) ? c : 2];
            out_ready = (c >= 4);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (ir_w[d] !== exp_ready(d) || ov_w[d] !== exp_valid(d) ||
                    (exp_valid(d) && (imm_w[d] !== m_imm[d][0] || ill_w[d] !== m_ill[d][0]))) begin
                    errors++;
                    $display("FAIL bp_model dut%0d cyc%0d: got rdy=%b vld=%b imm=%h, want rdy=%b vld=%b imm=%h",
                             d, c, ir_w[d], ov_w[d], imm_w[d], exp_ready(d), exp_valid(d), m_imm[d][0]);
                end
            end
            if (c == 2 || c == 3) begin
                vectors++;
                if (ir_b !== 1'b0 || ov_b !== 1'b1 || imm_b !== 64'd1) begin
                    errors++;
                    $display("FAIL bp_full cyc%0d: got rdy=%b vld=%b imm=%h, want 0 1 1", c, ir_b, ov_b, imm_b);
                end
            end
            if (c >= 4 && c <= 6) begin
                vectors++;
                if (ov_b !== 1'b1 || imm_b !== 64'(c - 3)) begin
                    errors++;
                    $display("FAIL bp_order cyc%0d: got vld=%b imm=%h, want 1 %0d", c, ov_b, imm_b, c - 3);
                end
            end
            if (c == 7) begin
                vectors++;
                if (ov_b !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_drain: got vld=%b, want 0", ov_b);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drain();
        immsrc = 3'd0;
        for (int c = 0; c < 7; c++) begin
            in_valid  = (c <= 2);
            instr     = 32'h00100093 + (32'(c) << 20);
            flush     = (c == 2);
            out_ready = (c >= 2);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (ir_w[d] !== exp_ready(d) || ov_w[d] !== exp_valid(d) ||
                    (exp_valid(d) && (imm_w[d] !== m_imm[d][0] || ill_w[d] !== m_ill[d][0]))) begin
                    errors++;
                    $display("FAIL flush_model dut%0d cyc%0d: got rdy=%b vld=%b imm=%h, want rdy=%b vld=%b imm=%h",
                             d, c, ir_w[d], ov_w[d], imm_w[d], exp_ready(d), exp_valid(d), m_imm[d][0]);
                end
            end
            if (c >= 3) begin
                vectors++;
                if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_empty cyc%0d: got vld_a=%b vld_b=%b, want 0 0", c, ov_a, ov_b);
                end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        drain();
        immsrc = 3'd0;
        for (int c = 0; c < 6; c++) begin
            in_valid  = (c <= 3);
            instr     = 32'h00100093 + (32'(c) << 20);
            reset     = (c == 2);
            out_ready = (c >= 3);
            #1;
            if (c != 2) begin
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (ir_w[d] !== exp_ready(d) || ov_w[d] !== exp_valid(d) ||
                        (exp_valid(d) && (imm_w[d] !== m_imm[d][0] || ill_w[d] !== m_ill[d][0]))) begin
                        errors++;
                        $display("FAIL rst_model dut%0d cyc%0d: got rdy=%b vld=%b imm=%h, want rdy=%b vld=%b imm=%h",
                                 d, c, ir_w[d], ov_w[d], imm_w[d], exp_ready(d), exp_valid(d), m_imm[d][0]);
                    end
                end
            end
            if (c == 3) begin
                vectors++;
                if (ov_a !== 1'b0 || ov_b !== 1'b0 || imm_a !== 32'd0 || imm_b !== 64'd0 ||
                    ill_a !== 1'b0 || ill_b !== 1'b0 || ir_a !== 1'b1 || ir_b !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_cleared: got vld=%b/%b imm=%h/%h ill=%b/%b rdy=%b/%b, want all 0 and rdy 1",
                             ov_a, ov_b, imm_a, imm_b, ill_a, ill_b, ir_a, ir_b);
                end
            end
            if (c == 4) begin
                vectors++;
                if (ov_a !== 1'b1 || imm_a !== 32'd4 || ov_b !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_first_x32: got vld_a=%b imm_a=%h vld_b=%b, want 1 4 0", ov_a, imm_a, ov_b);
                end
            end
            if (c == 5) begin
                vectors++;
                if (ov_b !== 1'b1 || imm_b !== 64'd4) begin
                    errors++;
                    $display("FAIL rst_first_x64: got vld=%b imm=%h, want 1 4", ov_b, imm_b);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            reset     = ($urandom_range(99) == 0);
            flush     = ($urandom_range(19) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            instr     = $urandom;
            immsrc    = 3'($urandom_range(7));
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (ir_w[d] !== exp_ready(d) || ov_w[d] !== exp_valid(d) ||
                    (exp_valid(d) && (imm_w[d] !== m_imm[d][0] || ill_w[d] !== m_ill[d][0]))) begin
                    errors++;
                    $display("FAIL random dut%0d step%0d: got rdy=%b vld=%b imm=%h ill=%b, want rdy=%b vld=%b imm=%h ill=%b",
                             d, n, ir_w[d], ov_w[d], imm_w[d], ill_w[d], exp_ready(d), exp_valid(d), m_imm[d][0], m_ill[d][0]);
                end
            end
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
